// File: rtl/uc_dedup_queue.sv
// Unit-clause FIFO between the unit clause arbiter and a process engine.
// It drops duplicate literals, flags a queued complement as a sticky conflict, and flushes in one cycle.
module uc_dedup_queue #(
    parameter int LIT_W = 9,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [LIT_W-1:0]             in_lit,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [LIT_W-1:0]             out_lit,
    input  logic                         out_ready,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         dup_drop,
    output logic                         conflict,
    output logic [LIT_W-1:0]             conf_lit
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;

    logic [LIT_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic             dup_drop_q, dup_drop_d;
    logic             conflict_q, conflict_d;
    logic [LIT_W-1:0] conf_lit_q, conf_lit_d;

    logic [PW-1:0]    occ;
    logic             full, empty;
    logic             accept, pop, store;
    logic             dup_hit, comp_hit;
    logic [LIT_W-1:0] comp_lit;

    // A slot is live when its distance from head is below the occupancy.
    function automatic logic slot_live(input logic [AW-1:0] idx,
                                       input logic [PW-1:0] hd,
                                       input logic [PW-1:0] oc);
        logic [AW-1:0] offs;
        offs = idx - hd[AW-1:0];
        return ({1'b0, offs} < oc);
    endfunction

    always_comb begin
        occ   = tail_q - head_q;
        empty = (head_q == tail_q);
        full  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    end

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_lit   = mem_q[head_q[AW-1:0]];
    assign count     = CNT_W'(occ);
    assign dup_drop  = dup_drop_q;
    assign conflict  = conflict_q;
    assign conf_lit  = conf_lit_q;

    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign comp_lit = {in_lit[LIT_W-1:1], ~in_lit[0]};

    // Match check covers every entry present at the start of the cycle, including a head popped now.
    always_comb begin
        dup_hit  = 1'b0;
        comp_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_live(AW'(i), head_q, occ)) begin
                if (mem_q[i] == in_lit)   dup_hit  = 1'b1;
                if (mem_q[i] == comp_lit) comp_hit = 1'b1;
            end
        end
    end

    always_comb begin
        store      = 1'b0;
        head_d     = head_q;
        tail_d     = tail_q;
        dup_drop_d = 1'b0;
        conflict_d = conflict_q;
        conf_lit_d = conf_lit_q;
        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            conflict_d = 1'b0;
            conf_lit_d = '0;
        end else begin
            if (accept && !conflict_q) begin
                if (dup_hit) begin
                    dup_drop_d = 1'b1;
                end else if (comp_hit) begin
                    conflict_d = 1'b1;
                    conf_lit_d = in_lit;
                end else begin
                    store = 1'b1;
                end
            end
            if (store) tail_d = tail_q + PW'(1);
            if (pop)   head_d = head_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            dup_drop_q <= 1'b0;
            conflict_q <= 1'b0;
            conf_lit_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            dup_drop_q <= dup_drop_d;
            conflict_q <= conflict_d;
            conf_lit_q <= conf_lit_d;
            if (store) mem_q[tail_q[AW-1:0]] <= in_lit;
        end
    end

endmodule

// File: tb/tb_uc_dedup_queue.sv
// Randomized and directed bench for uc_dedup_queue against a queue-based reference model.
module tb_uc_dedup_queue;

    localparam int LIT_W = 9;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [LIT_W-1:0] in_lit;
    logic             in_ready;
    logic             out_valid;
    logic [LIT_W-1:0] out_lit;
    logic             out_ready;
    logic             flush;
    logic [CNT_W-1:0] count;
    logic             dup_drop;
    logic             conflict;
    logic [LIT_W-1:0] conf_lit;

    always #5 clk = ~clk;

    uc_dedup_queue #(.LIT_W(LIT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_lit(in_lit), .in_ready(in_ready),
        .out_valid(out_valid), .out_lit(out_lit), .out_ready(out_ready),
        .flush(flush), .count(count), .dup_drop(dup_drop),
        .conflict(conflict), .conf_lit(conf_lit)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [LIT_W-1:0] mq[$];
    logic             m_conf;
    logic [LIT_W-1:0] m_conf_lit;
    logic             m_dup;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit has(input logic [LIT_W-1:0] l);
        foreach (mq[i]) if (mq[i] == l) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_conf     = 1'b0;
        m_conf_lit = '0;
        m_dup      = 1'b0;
    endtask

    task automatic check_state();
        chk("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("out_lit", 32'(out_lit), 32'(mq[0]));
        chk("count",     32'(count),     32'(mq.size()));
        chk("dup_drop",  32'(dup_drop),  32'(m_dup));
        chk("conflict",  32'(conflict),  32'(m_conf));
        chk("conf_lit",  32'(conf_lit),  32'(m_conf_lit));
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input logic iv, input logic [LIT_W-1:0] l, input logic ordy, input logic fl);
        bit acc, pp, st;
        in_valid  = iv;
        in_lit    = l;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        check_state();
        acc = iv && (mq.size() < DEPTH);
        pp  = ordy && (mq.size() != 0);
        st  = 1'b0;
        if (fl) begin
            model_clear();
        end else begin
            m_dup = 1'b0;
            if (acc && !m_conf) begin
                if (has(l)) m_dup = 1'b1;
                else if (has({l[LIT_W-1:1], ~l[0]})) begin
                    m_conf     = 1'b1;
                    m_conf_lit = l;
                end else st = 1'b1;
            end
            if (pp) void'(mq.pop_front());
            if (st) mq.push_back(l);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    logic [LIT_W-1:0] exp_order [4];
    logic [LIT_W-1:0] lit;
    int               guard;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_lit = '0; out_ready = 1'b0; flush = 1'b0;
        model_clear();
        #1;
        check_state();
        chk("rst_out_lit", 32'(out_lit), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fill to full, refused push, then ordered drain
        step(1'b1, 9'h010, 1'b0, 1'b0);
        step(1'b1, 9'h020, 1'b0, 1'b0);
        step(1'b1, 9'h030, 1'b0, 1'b0);
        step(1'b1, 9'h040, 1'b0, 1'b0);
        step(1'b1, 9'h050, 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_head", 32'(out_lit), 32'h010);
        exp_order[0] = 9'h010; exp_order[1] = 9'h020; exp_order[2] = 9'h030; exp_order[3] = 9'h040;
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 32'(out_lit), 32'(exp_order[i]));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Duplicate drop
        step(1'b1, 9'h010, 1'b0, 1'b0);
        step(1'b1, 9'h010, 1'b0, 1'b0);
        chk("dup_pulse", 32'(dup_drop), 32'd1);
        chk("dup_count", 32'(count), 32'd1);
        idle();
        chk("dup_once", 32'(dup_drop), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Conflict, discard while conflicted, flush clears
        step(1'b1, 9'h010, 1'b0, 1'b0);
        step(1'b1, 9'h011, 1'b0, 1'b0);
        chk("conf_set", 32'(conflict), 32'd1);
        chk("conf_lit", 32'(conf_lit), 32'h011);
        chk("conf_count", 32'(count), 32'd1);
        step(1'b1, 9'h020, 1'b0, 1'b0);
        chk("conf_drop", 32'(count), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("flush_conf", 32'(conflict), 32'd0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_lit", 32'(conf_lit), 32'h0);

        // Full with push+pop in the same cycle: pop only
        for (int i = 0; i < DEPTH; i++) step(1'b1, LIT_W'(9'h100 + 2 * i), 1'b0, 1'b0);
        step(1'b1, 9'h0a0, 1'b1, 1'b0);
        chk("fullpp_count", 32'(count), 32'd3);
        step(1'b1, 9'h0a0, 1'b0, 1'b0);
        chk("fullpp_next", 32'(count), 32'd4);
        step(1'b0, '0, 1'b0, 1'b1);

        // 3*DEPTH+1 distinct literals with random out_ready across pointer wrap
        for (int i = 0; i < 3 * DEPTH + 1; i++) begin
            lit = LIT_W'((i + 1) << 2);
            guard = 0;
            while (mq.size() >= DEPTH && guard < 50) begin
                step(1'b1, lit, 1'($urandom), 1'b0);
                guard++;
            end
            if (guard >= 50) chk("wrap_timeout", 32'(guard), 32'd0);
            step(1'b1, lit, 1'($urandom), 1'b0);
        end
        guard = 0;
        while (mq.size() != 0 && guard < 100) begin
            step(1'b0, '0, 1'($urandom), 1'b0);
            guard++;
        end
        chk("wrap_drained", 32'(out_valid), 32'd0);

        // Random traffic over a small literal pool to exercise dup/conflict/flush
        for (int i = 0; i < 400; i++) begin
            lit = LIT_W'(($urandom_range(5, 1) << 1) | ($urandom & 1));
            step(1'($urandom), lit, 1'($urandom), ($urandom % 25) == 0);
        end

        // Asynchronous reset mid-operation
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 9'h002, 1'b0, 1'b0);
        step(1'b1, 9'h004, 1'b0, 1'b0);
        step(1'b1, 9'h006, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        model_clear();
        in_valid = 1'b1; in_lit = 9'h008;
        @(posedge clk); #1;
        chk("rst_no_hs", 32'(count), 32'd0);
        rst = 1'b0;
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
